// File: rtl/div_unit_param.sv
// Parametrised multi-cycle restoring divider for the EXE-stage MDU.
// Supports signed/unsigned ops, 1 or 2 quotient bits per cycle, cancel and a divide-by-zero flag.
module div_unit_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_dvd;
    logic [WIDTH:0]     trial;

    // dvd shifts out dividend bits MSB first and shifts in quotient bits, so it ends up holding |q|.
    always_comb begin
        step_rem = rem_q;
        step_dvd = dvd_q;
        trial    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {step_rem, step_dvd[WIDTH-1]} - {1'b0, dsr_q};
            if (!trial[WIDTH]) begin
                step_rem = trial[WIDTH-1:0];
            end else begin
                step_rem = {step_rem[WIDTH-2:0], step_dvd[WIDTH-1]};
            end
            step_dvd = {step_dvd[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    q_neg_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    r_neg_d = signed_i & dividend_i[WIDTH-1];
                    dsr_d   = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
                    rem_d   = '0;
                    if (divisor_i == '0) begin
                        // Raw dividend is kept so it can be returned untouched as the remainder.
                        dz_d    = 1'b1;
                        dvd_d   = dividend_i;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                        cnt_d   = CNT_W'(N);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    if (dz_q) begin
                        quot_d = '1;
                        remo_d = dvd_q;
                    end else begin
                        quot_d = q_neg_q ? -dvd_q : dvd_q;
                        remo_d = r_neg_q ? -rem_q : rem_q;
                    end
                    div_zero_d = dz_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            quot_q     <= '0;
            remo_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = remo_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_div_unit_param.sv
// Self-checking bench for div_unit_param: three instances (32/1, 32/2, 16/2) checked against
// a behavioural reference model through an expected-result queue.
module tb_div_unit_param;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start  [3];
    logic        sgn    [3];
    logic        cancel [3];
    logic [31:0] dvd_in [3];
    logic [31:0] dsr_in [3];

    logic        busy_o [3];
    logic        done_o [3];
    logic        dz_o   [3];
    logic [31:0] q_o    [3];
    logic [31:0] r_o    [3];

    logic        busy_a, done_a, dz_a, busy_b, done_b, dz_b, busy_c, done_c, dz_c;
    logic [31:0] q_a, r_a, q_b, r_b;
    logic [15:0] q_c, r_c;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        sbq[$];
    logic [31:0] last_q [3];
    logic [31:0] last_r [3];
    logic        last_dz[3];

    always #5 clk = ~clk;

    div_unit_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(start[0]), .signed_i(sgn[0]), .cancel_i(cancel[0]),
        .dividend_i(dvd_in[0]), .divisor_i(dsr_in[0]), .busy_o(busy_a), .done_o(done_a),
        .quotient_o(q_a), .remainder_o(r_a), .div_zero_o(dz_a));

    div_unit_param #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(start[1]), .signed_i(sgn[1]), .cancel_i(cancel[1]),
        .dividend_i(dvd_in[1]), .divisor_i(dsr_in[1]), .busy_o(busy_b), .done_o(done_b),
        .quotient_o(q_b), .remainder_o(r_b), .div_zero_o(dz_b));

    div_unit_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut_c (
        .clk(clk), .rst(rst), .start_i(start[2]), .signed_i(sgn[2]), .cancel_i(cancel[2]),
        .dividend_i(dvd_in[2][15:0]), .divisor_i(dsr_in[2][15:0]), .busy_o(busy_c), .done_o(done_c),
        .quotient_o(q_c), .remainder_o(r_c), .div_zero_o(dz_c));

    always_comb begin
        busy_o[0] = busy_a;  done_o[0] = done_a;  dz_o[0] = dz_a;  q_o[0] = q_a;  r_o[0] = r_a;
        busy_o[1] = busy_b;  done_o[1] = done_b;  dz_o[1] = dz_b;  q_o[1] = q_b;  r_o[1] = r_b;
        busy_o[2] = busy_c;  done_o[2] = done_c;  dz_o[2] = dz_c;
        q_o[2] = {16'h0000, q_c};
        r_o[2] = {16'h0000, r_c};
    end

    function automatic int w_of(input int u);
        return (u == 2) ? 16 : 32;
    endfunction

    function automatic int n_of(input int u);
        return (u == 0) ? 32 : ((u == 1) ? 16 : 8);
    endfunction

    // Reference: C-style truncating division done in 64-bit integers.
    function automatic exp_t ref_model(input int w, input logic s, input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t        res;
        logic [31:0] mask, a, b;
        longint      sa, sb, qq, rr;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a_in & mask;
        b = b_in & mask;
        if (b == 32'd0) begin
            res.q  = mask;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            if (s && a[w-1]) sa = sa - (longint'(1) << w);
            if (s && b[w-1]) sb = sb - (longint'(1) << w);
            qq = sa / sb;
            rr = sa % sb;
            res.q  = 32'(qq) & mask;
            res.r  = 32'(rr) & mask;
            res.dz = 1'b0;
        end
        return res;
    endfunction

    // Called on a falling edge; returns on the falling edge just after the accepting edge.
    task automatic issue(input int u, input logic s, input logic [31:0] a, input logic [31:0] b);
        sgn[u]    = s;
        dvd_in[u] = a;
        dsr_in[u] = b;
        start[u]  = 1'b1;
        sbq.push_back(ref_model(w_of(u), s, a, b));
        @(negedge clk);
        start[u]  = 1'b0;
        dvd_in[u] = $urandom;
        dsr_in[u] = $urandom;
        sgn[u]    = ~s;
    endtask

    task automatic wait_done(input int u, input string name, input int poke, input bit check_pulse);
        int   lat      = 0;
        int   busy_cnt = 0;
        int   exp_lat;
        exp_t e;
        while (!done_o[u] && lat < 200) begin
            if (busy_o[u]) busy_cnt++;
            start[u] = (lat == poke);
            @(negedge clk);
            lat++;
        end
        start[u] = 1'b0;
        e = sbq.pop_front();
        exp_lat = e.dz ? 1 : n_of(u) + 1;
        vectors++;
        if (done_o[u] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s.timeout no done_o after %0d cycles, required at %0d", name, lat, exp_lat);
            return;
        end
        if (lat != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL %s.latency got %0d required %0d", name, lat, exp_lat);
        end
        vectors++;
        if (busy_cnt != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL %s.busy_cycles got %0d required %0d", name, busy_cnt, exp_lat);
        end
        vectors++;
        if (q_o[u] !== e.q) begin
            miscompares++;
            $display("[TB] FAIL %s.quotient got %h required %h", name, q_o[u], e.q);
        end
        vectors++;
        if (r_o[u] !== e.r) begin
            miscompares++;
            $display("[TB] FAIL %s.remainder got %h required %h", name, r_o[u], e.r);
        end
        vectors++;
        if (dz_o[u] !== e.dz) begin
            miscompares++;
            $display("[TB] FAIL %s.div_zero got %b required %b", name, dz_o[u], e.dz);
        end
        last_q[u]  = e.q;
        last_r[u]  = e.r;
        last_dz[u] = e.dz;
        if (check_pulse) begin
            @(negedge clk);
            vectors++;
            if (done_o[u] !== 1'b0 || busy_o[u] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s.pulse done/busy got %b/%b required 0/0", name, done_o[u], busy_o[u]);
            end
        end
    endtask

    task automatic check_held(input int u, input string name);
        vectors++;
        if (busy_o[u] !== 1'b0 || done_o[u] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s.idle busy/done got %b/%b required 0/0", name, busy_o[u], done_o[u]);
        end
        vectors++;
        if (q_o[u] !== last_q[u] || r_o[u] !== last_r[u] || dz_o[u] !== last_dz[u]) begin
            miscompares++;
            $display("[TB] FAIL %s.held q/r/dz got %h/%h/%b required %h/%h/%b", name,
                     q_o[u], r_o[u], dz_o[u], last_q[u], last_r[u], last_dz[u]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            last_q[u]  = 32'd0;
            last_r[u]  = 32'd0;
            last_dz[u] = 1'b0;
            check_held(u, "reset");
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        issue(0, 1'b0, 32'd100, 32'd7);               wait_done(0, "u_100_7", -1, 1'b1);
        issue(0, 1'b0, 32'hFFFF_FFF9, 32'd2);         wait_done(0, "u_big_2", -1, 1'b1);
        issue(0, 1'b0, 32'd3, 32'd9);                 wait_done(0, "u_small", -1, 1'b1);
    endtask

    task automatic test_signed();
        issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2);         wait_done(0, "s_m7_2", -1, 1'b1);
        issue(0, 1'b1, 32'd7, 32'hFFFF_FFFE);         wait_done(0, "s_7_m2", -1, 1'b1);
        issue(0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9); wait_done(0, "s_m100_m7", -1, 1'b1);
        issue(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(0, "s_min_m1", -1, 1'b1);
    endtask

    task automatic test_div_zero();
        issue(0, 1'b0, 32'd5, 32'd0);                 wait_done(0, "u_5_0", -1, 1'b1);
        issue(0, 1'b1, 32'hFFFF_FFF8, 32'd0);         wait_done(0, "s_m8_0", -1, 1'b1);
    endtask

    task automatic test_cancel();
        bit seen;
        issue(0, 1'b0, 32'd1000, 32'd10);             wait_done(0, "pre_cancel", -1, 1'b1);
        seen = 1'b0;
        sgn[0] = 1'b0; dvd_in[0] = 32'd100; dsr_in[0] = 32'd7; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            seen |= done_o[0];
        end
        cancel[0] = 1'b1;
        @(negedge clk);
        cancel[0] = 1'b0;
        check_held(0, "cancel_calc");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= done_o[0] | busy_o[0];
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL cancel_calc.no_done got done/busy activity required none");
        end
        // Cancel while in FIX (reached directly via divide-by-zero) must win over completion.
        sgn[0] = 1'b0; dvd_in[0] = 32'd5; dsr_in[0] = 32'd0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cancel[0] = 1'b1;
        @(negedge clk);
        cancel[0] = 1'b0;
        check_held(0, "cancel_fix");
        sgn[0] = 1'b0; dvd_in[0] = 32'd9; dsr_in[0] = 32'd3; start[0] = 1'b1; cancel[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; cancel[0] = 1'b0;
        check_held(0, "cancel_idle");
    endtask

    task automatic test_back_to_back();
        issue(0, 1'b0, 32'd100, 32'd7);               wait_done(0, "b2b_first", -1, 1'b0);
        issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        vectors++;
        if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b.accept done/busy got %b/%b required 0/1", done_o[0], busy_o[0]);
        end
        wait_done(0, "b2b_second", -1, 1'b1);
        issue(0, 1'b0, 32'd200, 32'd9);               wait_done(0, "start_while_busy", 5, 1'b1);
    endtask

    task automatic test_async_reset();
        sgn[0] = 1'b0; dvd_in[0] = 32'd100; dsr_in[0] = 32'd7; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) begin
            last_q[u]  = 32'd0;
            last_r[u]  = 32'd0;
            last_dz[u] = 1'b0;
        end
        check_held(0, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        issue(0, 1'b0, 32'd1000, 32'd10);             wait_done(0, "post_reset", -1, 1'b1);
    endtask

    task automatic test_bpc2();
        issue(1, 1'b0, 32'd100, 32'd7);               wait_done(1, "bpc2_100_7", -1, 1'b1);
        issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2);         wait_done(1, "bpc2_m7_2", -1, 1'b1);
        issue(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1, "bpc2_min_m1", -1, 1'b1);
        issue(1, 1'b0, 32'd5, 32'd0);                 wait_done(1, "bpc2_5_0", -1, 1'b1);
    endtask

    task automatic test_width16();
        issue(2, 1'b1, 32'h0000_8000, 32'h0000_FFFF); wait_done(2, "w16_min_m1", -1, 1'b1);
        issue(2, 1'b0, 32'h0000_FFFF, 32'd3);         wait_done(2, "w16_u_max_3", -1, 1'b1);
        issue(2, 1'b1, 32'h0000_FFF9, 32'd2);         wait_done(2, "w16_m7_2", -1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int          sel;
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 25; k++) begin
                a   = $urandom;
                sel = $urandom_range(0, 9);
                if (sel == 0)      b = 32'd0;
                else if (sel < 5)  b = $urandom_range(1, 20);
                else               b = $urandom;
                if (sel == 3 || sel == 4) b = -b;
                if (u == 2 && b[15:0] == 16'd0 && sel != 0) b = 32'd1;
                issue(u, 1'($urandom_range(0, 1)), a, b);
                wait_done(u, "random", -1, 1'b1);
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0; sgn[u] = 1'b0; cancel[u] = 1'b0;
            dvd_in[u] = 32'd0; dsr_in[u] = 32'd0;
        end
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        test_bpc2();
        test_width16();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
